psk_phase_mapper: RTL
=====================

# psk_phase_mapper

Parametrised M-PSK symbol-to-phase mapper with a valid/ready symbol input and a per-symbol hold counter. It succeeds the fixed QPSK phase selector. It supports BPSK, QPSK and 8PSK, an optional half-step (π/M) offset, and differential (DPSK-style) phase accumulation. It sits between the bit-to-symbol packer and the DDS/NCO phase input, and holds each phase word for SPS clock cycles.

## Interface
Parameters:
- PHASE_W, 14: phase word width; full circle = 2^PHASE_W. Legal range is 4 or more.
- SPS, 8: clock cycles per symbol; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  2  0 = BPSK (M=2), 1 = QPSK (M=4), 2 = 8PSK (M=8), 3 = reserved and treated as QPSK.
- diff_en  in  1  1 = differential phase accumulation.
- offset_en  in  1  1 = add a half step (2^PHASE_W / 2M) to the output.
- sym_data  in  3  symbol bits; only the low log2(M) bits are used.
- sym_valid  in  1  symbol present.
- sym_ready  out  1  mapper accepts a symbol this cycle.
- phase_mod  out  PHASE_W  phase word to the NCO.
- phase_va  out  1  phase_mod is valid.
- sym_start  out  1  one-cycle pulse on the first output cycle of each symbol.

## Operation
- Handshake: a symbol is accepted on a clk edge where sym_valid && sym_ready. mode, diff_en, offset_en and sym_data are all sampled at acceptance only.
- Index derivation:
  - k = log2(M).
  - r = bit-reverse of sym_data[k-1:0].
  - idx = Gray-to-binary of r.
- Step and offset:
  - step = 2^PHASE_W / M.
  - off = offset_en ? step/2 : 0.
- Non-differential: acc <= idx*step; phase_mod <= idx*step + off.
- Differential: acc <= acc + idx*step; phase_mod <= acc + idx*step + off.
- All phase arithmetic is modulo 2^PHASE_W; carries are dropped.
- acc is PHASE_W bits wide and is not cleared by mode changes. A non-differential symbol re-seeds it, so a later differential run starts from the last absolute phase.
- States:
  - IDLE: sym_ready = 1; phase_va = 0; phase_mod holds its last value.
  - HOLD: phase_va = 1; cnt counts SPS-1 down to 0; sym_ready = 1 only when cnt == 0.
- Transitions:
  - IDLE → HOLD on accept.
  - HOLD(cnt==0) with accept → HOLD, new symbol, cnt = SPS-1. This is the back-to-back case with no gap.
  - HOLD(cnt==0) without accept → IDLE.
- SPS = 1: sym_ready is permanently 1 outside reset, giving one symbol per cycle.
- Reset values:
  - state = IDLE.
  - cnt = 0, acc = 0.
  - phase_mod = 0.
  - phase_va = 0, sym_start = 0.
  - sym_ready forced to 0 while reset is high.

## Timing
- Latency: a symbol accepted at edge N drives phase_mod, phase_va = 1 and sym_start = 1 after edge N.
- phase_mod is stable for exactly SPS cycles per symbol.
- sym_ready is combinational from state and cnt only. It has no dependency on sym_valid, so there is no combinational loop.
- Underrun: if no symbol is accepted at cnt == 0, phase_va drops on the next cycle and phase_mod retains its last value.
- Reset mid-symbol: outputs clear asynchronously, acc clears, and the in-flight symbol is lost. The first accept after reset release behaves exactly as from power-up.
- sym_start stays high for exactly one cycle per accepted symbol, including back-to-back symbols.

## Structure
- Shared package psk_pkg:
  - mode encoding constants (MODE_BPSK, MODE_QPSK, MODE_8PSK);
  - function bits_per_sym(mode);
  - function gray2bin;
  - function bitrev3.
- One sub-module: psk_sym_index. It is purely combinational and maps {mode, sym_data} to idx[2:0] and the step shift.
- Top level holds the FSM, cnt, acc and output registers.

## Test plan
- QPSK, offset_en = 1, diff_en = 0, PHASE_W = 14, SPS = 4; symbols 0, 1, 2, 3 back-to-back. Expect phase_mod = 2048, 14336, 6144, 10240, each held 4 cycles. phase_va stays high throughout, and sym_start pulses every 4th cycle.
- BPSK with offset: sym 0 → 4096, sym 1 → 12288. 8PSK without offset: sym 3 → 8192, sym 0 → 0.
- DQPSK, offset_en = 0, symbols 2, 2, 0, 3. Expect 4096, 8192, 8192, 0, where the last value wraps from 8192 + 8192 = 16384 to 0.
- Underrun and stall, QPSK: one symbol with sym_valid then low. Expect phase_va = 0 after SPS cycles and phase_mod held. Next, sym_valid held high throughout. Expect sym_ready high only on cnt == 0 cycles.
- reset asserted mid-HOLD in differential mode:
  - expect immediate phase_mod = 0, phase_va = 0 and sym_ready = 0;
  - after release, a DQPSK sym 2 must give 4096, proving acc was cleared.
- SPS = 1: continuous valid symbols. Expect a new phase every cycle, with sym_ready constantly high.

Source files
------------

// File: rtl/psk_pkg.sv
// Shared definitions for the M-PSK phase mapper.
//   - mode encodings (BPSK / QPSK / 8PSK; encoding 3 is reserved and decodes as QPSK)
//   - FSM state type and the sampled-request bundle
//   - helpers: bits_per_sym, gray2bin, bitrev3
package psk_pkg;

    localparam logic [1:0] MODE_BPSK = 2'd0;
    localparam logic [1:0] MODE_QPSK = 2'd1;
    localparam logic [1:0] MODE_8PSK = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } psk_state_e;

    // Everything that is sampled together at symbol acceptance.
    typedef struct packed {
        logic [1:0] mode;
        logic       diff_en;
        logic       offset_en;
        logic [2:0] sym_data;
    } psk_req_t;

    // k = log2(M); the reserved mode falls through to the QPSK value.
    function automatic logic [1:0] bits_per_sym(input logic [1:0] mode);
        case (mode)
            MODE_BPSK: return 2'd1;
            MODE_8PSK: return 2'd3;
            default:   return 2'd2;
        endcase
    endfunction

    // A 3-bit Gray decode also decodes 1- and 2-bit codes when the unused
    // upper bits are zero, so one helper serves every mode.
    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] d);
        return {d[0], d[1], d[2]};
    endfunction

endpackage

// File: rtl/psk_phase_mapper_if.sv
// Symbol-in / phase-out bundle of the phase mapper.
//   master : symbol producer (drives mode, diff_en, offset_en, sym_data, sym_valid;
//            observes sym_ready and the phase outputs)
//   slave  : the mapper itself
interface psk_phase_mapper_if #(
    parameter int PHASE_W = 14
);
    logic [1:0]         mode;
    logic               diff_en;
    logic               offset_en;
    logic [2:0]         sym_data;
    logic               sym_valid;
    logic               sym_ready;
    logic [PHASE_W-1:0] phase_mod;
    logic               phase_va;
    logic               sym_start;

    modport master (
        output mode, diff_en, offset_en, sym_data, sym_valid,
        input  sym_ready, phase_mod, phase_va, sym_start
    );

    modport slave (
        input  mode, diff_en, offset_en, sym_data, sym_valid,
        output sym_ready, phase_mod, phase_va, sym_start
    );
endinterface

// File: rtl/psk_sym_index.sv
// Combinational symbol-to-constellation-index mapping.
//   mode       in  2  constellation select
//   sym_data   in  3  raw symbol bits (only the low k bits matter)
//   idx        out 3  constellation point index (0..M-1)
//   step_shift out 2  k = log2(M); phase step is 2^PHASE_W >> k
module psk_sym_index
    import psk_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [2:0] sym_data,
    output logic [2:0] idx,
    output logic [1:0] step_shift
);

    logic [1:0] k;
    logic [2:0] masked;
    logic [2:0] rev;

    always_comb begin
        k          = bits_per_sym(mode);
        masked     = sym_data & ((3'd1 << k) - 3'd1);
        // Reverse all three bits, then shift the k reversed bits back down.
        rev        = bitrev3(masked) >> (2'd3 - k);
        idx        = gray2bin(rev);
        step_shift = k;
    end

endmodule

// File: rtl/psk_phase_mapper.sv
// M-PSK symbol-to-phase mapper with per-symbol hold.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high reset
//   bus    slave side of psk_phase_mapper_if:
//            mode/diff_en/offset_en/sym_data/sym_valid in, sym_ready out,
//            phase_mod (PHASE_W) / phase_va / sym_start out
// Each accepted symbol is held on phase_mod for SPS cycles. The next symbol
// may be accepted on the last hold cycle, giving gap-free streaming.
module psk_phase_mapper
    import psk_pkg::*;
#(
    parameter int PHASE_W = 14,
    parameter int SPS     = 8
) (
    input  logic               clk,
    input  logic               reset,
    psk_phase_mapper_if.slave  bus
);

    localparam int                CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SPS - 1);

    psk_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W-1:0] phase_q;
    logic               va_q;
    logic               start_q;
    logic               sym_ready;
    logic               accept;

    psk_req_t           req;
    logic [2:0]         idx;
    logic [1:0]         step_shift;
    logic [PHASE_W-1:0] idx_step;
    logic [PHASE_W-1:0] half_step;
    logic [PHASE_W-1:0] acc_next;

    assign req = '{mode:      bus.mode,
                   diff_en:   bus.diff_en,
                   offset_en: bus.offset_en,
                   sym_data:  bus.sym_data};

    psk_sym_index u_index (
        .mode       (req.mode),
        .sym_data   (req.sym_data),
        .idx        (idx),
        .step_shift (step_shift)
    );

    // idx * (2^PHASE_W / M) is a left shift by PHASE_W - k; the half step is
    // one bit lower. Sums wrap naturally at PHASE_W bits.
    always_comb begin
        idx_step  = PHASE_W'(idx) << (PHASE_W - int'(step_shift));
        half_step = req.offset_en ? (PHASE_W'(1) << (PHASE_W - 1 - int'(step_shift)))
                                  : '0;
        acc_next  = req.diff_en ? (acc_q + idx_step) : idx_step;
    end

    assign accept = bus.sym_valid & sym_ready;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and ready. Ready depends only on state/cnt (and reset),
    // never on sym_valid.
    always_comb begin
        state_d   = state_q;
        sym_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sym_ready = 1'b1;
                if (accept) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                sym_ready = (cnt_q == '0);
                if (cnt_q == '0 && !accept) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) sym_ready = 1'b0;
    end

    // Datapath: hold counter, phase accumulator, output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            phase_q <= '0;
            va_q    <= 1'b0;
            start_q <= 1'b0;
        end else if (accept) begin
            cnt_q   <= CNT_LOAD;
            acc_q   <= acc_next;
            phase_q <= acc_next + half_step;
            va_q    <= 1'b1;
            start_q <= 1'b1;
        end else begin
            start_q <= 1'b0;
            if (state_q == ST_HOLD) begin
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else             va_q  <= 1'b0;   // underrun: phase_mod keeps last value
            end
        end
    end

    assign bus.sym_ready = sym_ready;
    assign bus.phase_mod = phase_q;
    assign bus.phase_va  = va_q;
    assign bus.sym_start = start_q;

endmodule
